// File: rtl/spi_3w_slave_regs_if.sv
// Link and register-event signals between the 3-wire SPI master and the slave register file.
// The bidirectional sdio line is a plain module port so the tristate resolves at the module boundary.
interface spi_3w_slave_regs_if #(
    parameter int a_width = 16,
    parameter int d_width = 8
);
    logic               sclk;
    logic               cs;
    logic               wr_stb;
    logic [a_width-1:0] wr_addr;
    logic [d_width-1:0] wr_data;
    logic               rd_stb;
    logic               frame_err;

    modport slave (
        input  sclk, cs,
        output wr_stb, wr_addr, wr_data, rd_stb, frame_err
    );

    modport master (
        output sclk, cs,
        input  wr_stb, wr_addr, wr_data, rd_stb, frame_err
    );
endinterface

// File: rtl/spi_3w_slave_regs.sv
// 3-wire SPI slave with a register file. Frames are: 2 instruction bits, an address, then data.
// sclk and cs are sampled directly on clk; sdio is sampled on sclk falls and driven only during read data.
module spi_3w_slave_regs #(
    parameter int a_width = 16,
    parameter int d_width = 8,
    parameter int depth   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_3w_slave_regs_if.slave bus,
    inout  wire                sdio,
    input  logic [a_width-1:0] dbg_addr,
    output logic [d_width-1:0] dbg_data
);
    localparam int cnt_w = $clog2(((a_width > d_width) ? a_width : d_width) + 1);
    localparam int idx_w = $clog2(depth);
    localparam logic [a_width-1:0] depth_a = a_width'(depth);
    localparam logic [cnt_w-1:0]   last_i  = cnt_w'(1);
    localparam logic [cnt_w-1:0]   last_a  = cnt_w'(a_width - 1);
    localparam logic [cnt_w-1:0]   last_d  = cnt_w'(d_width - 1);

    typedef enum logic [2:0] {IDLE, INST, ADDR, WDATA, RDATA, SKIP} state_t;

    state_t             state, state_d;
    logic               sclk_q;
    logic               fall;
    logic [cnt_w-1:0]   bit_cnt;
    logic [1:0]         inst_sr;
    logic [a_width-1:0] addr_sr;
    logic [d_width-2:0] data_sr;
    logic [d_width-1:0] rd_sr;
    logic               drive_en;
    logic               sdo;
    logic [d_width-1:0] regs [depth];

    logic [1:0]         inst_full;
    logic [a_width-1:0] addr_full;
    logic [d_width-1:0] data_full;
    logic               cnt_clr, cnt_inc;
    logic               shift_i, shift_a, shift_d, shift_r;
    logic               load_rd, commit, rd_end, abort, inst_err;

    assign fall      = ~bus.sclk & sclk_q;
    assign inst_full = {inst_sr[0], sdio};
    assign addr_full = {addr_sr[a_width-2:0], sdio};
    assign data_full = {data_sr, sdio};
    assign sdo       = rd_sr[d_width-1];
    assign sdio      = drive_en ? sdo : 1'bz;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        shift_i  = 1'b0;
        shift_a  = 1'b0;
        shift_d  = 1'b0;
        shift_r  = 1'b0;
        load_rd  = 1'b0;
        commit   = 1'b0;
        rd_end   = 1'b0;
        abort    = 1'b0;
        inst_err = 1'b0;
        // cs is checked before fall in every active state: a cs rise beats a same-clk fall.
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!bus.cs) state_d = INST;
            end
            INST: begin
                if (bus.cs) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    shift_i = 1'b1;
                    if (bit_cnt == last_i) begin
                        cnt_clr = 1'b1;
                        if (inst_full == 2'b11 || inst_full == 2'b00) begin
                            state_d = ADDR;
                        end else begin
                            inst_err = 1'b1;
                            state_d  = SKIP;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (bus.cs) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    shift_a = 1'b1;
                    if (bit_cnt == last_a) begin
                        cnt_clr = 1'b1;
                        if (inst_sr == 2'b11) begin
                            load_rd = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = WDATA;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            WDATA: begin
                if (bus.cs) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    shift_d = 1'b1;
                    if (bit_cnt == last_d) begin
                        commit  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = SKIP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (bus.cs) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (fall) begin
                    if (bit_cnt == last_d) begin
                        rd_end  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = SKIP;
                    end else begin
                        shift_r = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            SKIP: begin
                if (bus.cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the register array is reset explicitly because cleared contents after rst_n are required behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q        <= 1'b0;
            bit_cnt       <= '0;
            inst_sr       <= '0;
            addr_sr       <= '0;
            data_sr       <= '0;
            rd_sr         <= '0;
            drive_en      <= 1'b0;
            bus.wr_stb    <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.rd_stb    <= 1'b0;
            bus.frame_err <= 1'b0;
            for (int i = 0; i < depth; i++) regs[i] <= '0;
        end else begin
            sclk_q        <= bus.sclk;
            bus.wr_stb    <= 1'b0;
            bus.rd_stb    <= 1'b0;
            bus.frame_err <= abort | inst_err;

            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;

            if (shift_i) inst_sr <= inst_full;
            if (shift_a) addr_sr <= addr_full;
            if (shift_d) data_sr <= data_full[d_width-2:0];
            if (shift_r) rd_sr   <= rd_sr << 1;

            if (load_rd) begin
                rd_sr      <= (addr_full < depth_a) ? regs[addr_full[idx_w-1:0]] : '0;
                drive_en   <= 1'b1;
                bus.rd_stb <= 1'b1;
            end
            if (rd_end || abort) drive_en <= 1'b0;

            if (commit) begin
                if (addr_sr < depth_a) begin
                    regs[addr_sr[idx_w-1:0]] <= data_full;
                    bus.wr_stb  <= 1'b1;
                    bus.wr_addr <= addr_sr;
                    bus.wr_data <= data_full;
                end else begin
                    bus.frame_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr < depth_a) dbg_data = regs[dbg_addr[idx_w-1:0]];
    end
endmodule
